// File: rtl/fp_pkg.sv
// Shared single-precision floating-point definitions: field widths, bias,
// the common 2-bit sequencer encoding and small integer helpers.
package fp_pkg;

   localparam int EXP_BIAS = 127;
   localparam int EXP_W    = 8;
   localparam int MANT_W   = 23;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_NORM  = 2'd1,
      ST_ROUND = 2'd2,
      ST_DONE  = 2'd3
   } fp_state_e;

   // Magnitude of a two's-complement word; 0x80000000 maps to 2^31 unsigned.
   function automatic logic [31:0] abs32(input logic [31:0] v);
      logic [31:0] r;
      if (v[31]) begin
         r = ~v + 32'd1;
      end else begin
         r = v;
      end
      return r;
   endfunction

endpackage : fp_pkg

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a truncated mantissa; carry_o flags mantissa
// overflow, in which case mant_o is all zeros and the caller bumps the exponent.
module fp_round_rne
   import fp_pkg::*;
(
   input  logic [MANT_W-1:0] mant_i,
   input  logic              guard_i,
   input  logic              sticky_i,
   output logic [MANT_W-1:0] mant_o,
   output logic              carry_o
);

   logic            inc_s;
   logic [MANT_W:0] sum_s;

   assign inc_s   = guard_i & (sticky_i | mant_i[0]);
   assign sum_s   = {1'b0, mant_i} + {{MANT_W{1'b0}}, inc_s};
   assign mant_o  = sum_s[MANT_W-1:0];
   assign carry_o = sum_s[MANT_W];

endmodule : fp_round_rne

// File: rtl/int2fp.sv
// Multi-cycle int32 to IEEE-754 single converter: normalize by one bit per
// cycle, round to nearest even, then hold the result until the next one.
module int2fp
   import fp_pkg::*;
#(
   parameter int EXP_INIT = EXP_BIAS + 31
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] a,
   output logic [31:0] result,
   output logic        done,
   output logic        busy
);

   fp_state_e          state_q, state_d;
   logic               sign_q, sign_d;
   logic [31:0]        mag_q, mag_d;
   logic [EXP_W-1:0]   exp_q, exp_d;
   logic [31:0]        result_q, result_d;
   logic               done_q, done_d;
   logic               busy_q, busy_d;

   logic [MANT_W-1:0]  mant_rnd_s;
   logic               carry_s;
   logic [EXP_W-1:0]   exp_rnd_s;

   fp_round_rne u_round (
      .mant_i   (mag_q[30:8]),
      .guard_i  (mag_q[7]),
      .sticky_i (|mag_q[6:0]),
      .mant_o   (mant_rnd_s),
      .carry_o  (carry_s)
   );

   assign exp_rnd_s = exp_q + {{(EXP_W-1){1'b0}}, carry_s};

   // Next-state and datapath updates for the conversion sequencer.
   always_comb begin
      state_d  = state_q;
      sign_d   = sign_q;
      mag_d    = mag_q;
      exp_d    = exp_q;
      result_d = result_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               sign_d  = a[31];
               mag_d   = abs32(a);
               exp_d   = EXP_W'(EXP_INIT);
               state_d = ST_NORM;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_NORM: begin
            if (mag_q == 32'd0) begin
               result_d = 32'h0000_0000;
               state_d  = ST_DONE;
            end else if (mag_q[31]) begin
               state_d = ST_ROUND;
            end else begin
               mag_d = {mag_q[30:0], 1'b0};
               exp_d = exp_q - {{(EXP_W-1){1'b0}}, 1'b1};
            end
         end
         ST_ROUND: begin
            // All int32 magnitudes land in the normal range; no special encodings.
            result_d = {sign_q, exp_rnd_s, mant_rnd_s};
            exp_d    = exp_rnd_s;
            state_d  = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // done follows the DONE state by one register stage.
      done_d = (state_q == ST_DONE);
      busy_d = (state_d != ST_IDLE);
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         sign_q   <= 1'b0;
         mag_q    <= 32'd0;
         exp_q    <= {EXP_W{1'b0}};
         result_q <= 32'h0000_0000;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sign_q   <= sign_d;
         mag_q    <= mag_d;
         exp_q    <= exp_d;
         result_q <= result_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
      end
   end

   assign result = result_q;
   assign done   = done_q;
   assign busy   = busy_q;

endmodule : int2fp

// File: tb/tb_int2fp.sv
// Directed self-checking bench for int2fp: latency, rounding, busy-time
// start handling and reset abort.
module tb_int2fp;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [31:0] a = 32'd0;
   logic [31:0] result;
   logic        done;
   logic        busy;

   int n_pass  = 0;
   int n_total = 0;

   int2fp dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .a      (a),
      .result (result),
      .done   (done),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      n_total++;
      if ({busy, done, result} !== 34'd0) begin
         $display("FAIL reset_state: busy=%0b done=%0b result=%h, want 0/0/00000000", busy, done, result);
      end else begin
         n_pass++;
      end
      reset = 1'b0;
      tick();
   endtask

   // One conversion; checks done latency (edges after the sampling edge), result, pulse width.
   task automatic convert(input logic [31:0] val, input logic [31:0] exp_res, input int exp_lat, input string name);
      int n;
      start = 1'b1;
      a     = val;
      tick();
      start = 1'b0;
      a     = 32'hDEAD_BEEF;
      n_total++;
      if (busy !== 1'b1) begin
         $display("FAIL %s_busy: busy=%0b, want 1", name, busy);
      end else begin
         n_pass++;
      end
      n = 1;
      tick();
      while (done !== 1'b1 && n < 60) begin
         n++;
         tick();
      end
      n_total++;
      if (n !== exp_lat) begin
         $display("FAIL %s_latency: done after %0d edges, want %0d", name, n, exp_lat);
      end else begin
         n_pass++;
      end
      n_total++;
      if (result !== exp_res) begin
         $display("FAIL %s_result: result=%h, want %h", name, result, exp_res);
      end else begin
         n_pass++;
      end
      tick();
      n_total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         $display("FAIL %s_pulse: done=%0b busy=%0b after pulse, want 0/0", name, done, busy);
      end else begin
         n_pass++;
      end
   endtask

   task automatic test_basic();
      convert(32'd1,          32'h3F80_0000, 34, "one");
      convert(32'd0,          32'h0000_0000,  2, "zero");
      convert(32'hFFFF_FFFF,  32'hBF80_0000, 34, "minus_one");
      convert(32'd2,          32'h4000_0000, 33, "two");
      convert(32'hFFFF_FFFB,  32'hC0A0_0000, 32, "minus_five");
      convert(32'd100,        32'h42C8_0000, 28, "hundred");
   endtask

   task automatic test_boundaries();
      convert(32'h7FFF_FFFF,  32'h4F00_0000,  4, "int_max");
      convert(32'h8000_0000,  32'hCF00_0000,  3, "int_min");
   endtask

   task automatic test_ties_even();
      convert(32'd16777217,   32'h4B80_0000, 10, "tie_217");
      convert(32'd16777219,   32'h4B80_0002, 10, "tie_219");
      convert(32'd16777221,   32'h4B80_0002, 10, "tie_221");
   endtask

   task automatic test_busy_start();
      int pulses;
      int first;
      start = 1'b1;
      a     = 32'd1;
      tick();
      a = 32'd5;
      pulses = 0;
      first  = 0;
      for (int i = 1; i <= 45; i++) begin
         start = (i < 6);
         a     = 32'd5 + 32'(i);
         tick();
         if (done === 1'b1) begin
            pulses++;
            if (first == 0) first = i;
         end
      end
      n_total++;
      if (pulses !== 1 || first !== 34) begin
         $display("FAIL busy_start_pulses: %0d pulses first at %0d, want 1 at 34", pulses, first);
      end else begin
         n_pass++;
      end
      n_total++;
      if (result !== 32'h3F80_0000) begin
         $display("FAIL busy_start_result: result=%h, want 3f800000", result);
      end else begin
         n_pass++;
      end
   endtask

   // Start asserted while the sequencer sits in DONE must not launch a conversion.
   task automatic test_back_to_back();
      start = 1'b1;
      a     = 32'h8000_0000;
      tick();
      start = 1'b0;
      tick();
      tick();
      start = 1'b1;
      a     = 32'd1;
      tick();
      start = 1'b0;
      n_total++;
      if (done !== 1'b1 || busy !== 1'b0 || result !== 32'hCF00_0000) begin
         $display("FAIL b2b_ignore: done=%0b busy=%0b result=%h, want 1/0/cf000000", done, busy, result);
      end else begin
         n_pass++;
      end
      tick();
      n_total++;
      if (busy !== 1'b0) begin
         $display("FAIL b2b_idle: busy=%0b, want 0", busy);
      end else begin
         n_pass++;
      end
      convert(32'd2, 32'h4000_0000, 33, "b2b_next");
   endtask

   task automatic test_reset_abort();
      int pulses;
      start = 1'b1;
      a     = 32'd1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      reset = 1'b1;
      start = 1'b1;
      a     = 32'd7;
      tick();
      reset = 1'b0;
      start = 1'b0;
      n_total++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
         $display("FAIL abort_state: busy=%0b done=%0b result=%h, want 0/0/00000000", busy, done, result);
      end else begin
         n_pass++;
      end
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done === 1'b1 || busy === 1'b1) pulses++;
      end
      n_total++;
      if (pulses !== 0) begin
         $display("FAIL abort_quiet: %0d active cycles after reset, want 0", pulses);
      end else begin
         n_pass++;
      end
      convert(32'd100, 32'h42C8_0000, 28, "after_abort");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_boundaries();
      test_ties_even();
      test_busy_start();
      test_back_to_back();
      test_reset_abort();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_int2fp
